grid_mem_arbiter: RTL
=====================

# grid_mem_arbiter

Shares one single-port 128x2 grid memory between the VGA scan reader and the gameplay controller. VGA reads get priority during active video. A bounded-wait counter guarantees gameplay read/write requests are served within `WAIT_MAX` cycles. The block sits between the gameplay FSM, the VGA pixel pipeline and each grid RAM instance (place grid, shoot grid).

## Interface
**Parameters**
- `WAIT_MAX`, default 15: maximum cycles a pending gameplay request is denied before it pre-empts VGA. If 0, gameplay always wins.
- `CNT_W`, default 4: width of the wait counter. Must satisfy `WAIT_MAX < 2**CNT_W`.

**Ports**
- `clk`  in  1: system clock; all state on rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `vga_req`  in  1: scan read request this cycle.
- `vga_addr`  in  7: scan cell address.
- `vga_data`  out  2: scan read data, held between updates.
- `vga_valid`  out  1: `vga_data` updated this cycle.
- `vga_miss`  out  1: a VGA request was displaced; `vga_data` is stale.
- `gp_req`  in  1: gameplay request; held until `gp_ack`.
- `gp_we`  in  1: 1 = write, 0 = read.
- `gp_addr`  in  7: gameplay cell address.
- `gp_wdata`  in  2: gameplay write data.
- `gp_ack`  out  1: one-cycle completion pulse.
- `gp_rdata`  out  2: read data, valid with `gp_ack` on reads.
- `mem_addr`  out  7: RAM address.
- `mem_wdata`  out  2: RAM write data.
- `mem_we`  out  1: RAM write enable.
- `mem_oe`  out  1: RAM read enable.
- `mem_rdata`  in  2: RAM data, registered, valid one cycle after `mem_oe`.

## Operation
- **Slot decision each cycle**
  - `gp_pend = gp_req & ~gp_inflight`.
  - GP slot if `gp_pend & (~vga_req | wait_cnt == WAIT_MAX)`.
  - Else VGA slot if `vga_req`.
  - Else NONE.
- **Memory drive (combinational from slot decision)**
  - GP slot: `mem_addr=gp_addr`, `mem_we=gp_we`, `mem_oe=~gp_we`, `mem_wdata=gp_wdata`.
  - VGA slot: `mem_addr=vga_addr`, `mem_oe=1`, `mem_we=0`.
  - NONE: `mem_we=0`, `mem_oe=0`, `mem_addr` and `mem_wdata` hold 0.
- **Owner tag FSM (registered)**
  - States: IDLE, VGA_RESP, GP_RESP, GP_RESP_MISS.
  - The next state is the owner of the current slot. GP_RESP_MISS applies when GP was granted while `vga_req=1`.
  - IDLE: no response outputs.
  - VGA_RESP: `vga_data<=mem_rdata`, `vga_valid=1`.
  - GP_RESP / GP_RESP_MISS: `gp_ack=1`, `gp_rdata=mem_rdata` on reads, `gp_rdata` holds its last value on writes.
  - GP_RESP_MISS additionally drives `vga_miss=1`; `vga_data` is unchanged.
- **`gp_inflight`**
  - Set on a GP grant; cleared at the end of the ack cycle.
  - The request is never regranted while in flight.
  - `gp_req` high in the cycle after `gp_ack` is a new request.
- **`wait_cnt`**
  - Increments each cycle `gp_pend` is denied, saturating at `WAIT_MAX`.
  - Clears on a GP grant or when `gp_req=0`.
- **Transaction rules**
  - One gameplay transaction outstanding at most.
  - Gameplay inputs must be stable from `gp_req` rise through the grant cycle.
- **Reset**
  - All outputs 0, state IDLE, `gp_inflight=0`, `wait_cnt=0`.
  - Asserting reset mid-transaction abandons it: no `gp_ack` is issued, and the requester must re-request.

## Timing
- **Latency**
  - Grant in cycle N.
  - `vga_valid`/`vga_data`, or `gp_ack`/`gp_rdata`, in cycle N+1.
  - A write commits at the edge ending cycle N.
- **Throughput**
  - One memory access per cycle.
  - Gameplay at best one transaction per 2 cycles.
- **Worst-case gameplay wait:** `WAIT_MAX` denied cycles, grant on cycle `WAIT_MAX+1`, ack on cycle `WAIT_MAX+2` after `gp_req` rise.
- **Simultaneous requests**
  - `vga_req` and `gp_pend` both high with `wait_cnt<WAIT_MAX`: VGA wins.
  - At `WAIT_MAX`: GP wins, and `vga_miss` pulses in N+1.
- **Reset release:** the first grant is possible in the first cycle after `rst_n` deasserts.

## Test plan
1. **Reset values:** assert `rst_n=0` mid-GP-read (tag GP_RESP).
   - All outputs go to 0 immediately.
   - After release, no `gp_ack` appears until `gp_req` is reasserted.
2. **Idle-bus write then read:** `vga_req=0`; write `gp_addr=7'h2A`, `gp_wdata=2'b10`.
   - `mem_we=1` in cycle N, `gp_ack` in N+1.
   - Subsequent read of `7'h2A`: `gp_ack` with `gp_rdata=2'b10`.
3. **VGA streaming:** `vga_req=1` continuously, addresses 0..127, no gameplay traffic.
   - `vga_valid=1` every cycle from cycle 1.
   - `vga_data` equals RAM contents one cycle late.
   - `vga_miss` never asserts.
4. **Starvation bound:** `WAIT_MAX=15`, `vga_req=1` continuously, `gp_req` rises at cycle T.
   - GP granted at T+15, `gp_ack` and `vga_miss` at T+16.
   - `vga_data` holds its T+15 value through T+16, and VGA resumes at T+17.
5. **Back-to-back gameplay:** `gp_req` held high across 4 reads, `vga_req=0`.
   - Grants at cycles 0, 2, 4, 6 and acks at 1, 3, 5, 7.
   - No duplicate grant during the in-flight cycles.
6. **`WAIT_MAX=0`:** `vga_req=1`, `gp_req=1`.
   - GP granted in the same cycle `gp_req` rises, with `vga_miss` in the next cycle.

Source files
------------

// File: rtl/grid_mem_if.sv
// Bundles the VGA scan port, gameplay port and grid RAM port of one arbiter.
// The master modport is the requester/RAM side; the slave modport is the arbiter.
interface grid_mem_if;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 2;

    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_data;
    logic              vga_valid;
    logic              vga_miss;

    logic              gp_req;
    logic              gp_we;
    logic [ADDR_W-1:0] gp_addr;
    logic [DATA_W-1:0] gp_wdata;
    logic              gp_ack;
    logic [DATA_W-1:0] gp_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_oe;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output vga_req, vga_addr, gp_req, gp_we, gp_addr, gp_wdata, mem_rdata,
        input  vga_data, vga_valid, vga_miss, gp_ack, gp_rdata,
               mem_addr, mem_wdata, mem_we, mem_oe
    );

    modport slave (
        input  vga_req, vga_addr, gp_req, gp_we, gp_addr, gp_wdata, mem_rdata,
        output vga_data, vga_valid, vga_miss, gp_ack, gp_rdata,
               mem_addr, mem_wdata, mem_we, mem_oe
    );
endinterface

// File: rtl/grid_mem_arbiter.sv
// Single-port grid RAM arbiter: VGA scan reads have priority, gameplay
// requests are guaranteed a slot after WAIT_MAX denied cycles.
module grid_mem_arbiter #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    grid_mem_if.slave  bus
);
    localparam int unsigned DATA_W = 2;

    localparam logic [1:0] ST_IDLE         = 2'b00;
    localparam logic [1:0] ST_VGA_RESP     = 2'b01;
    localparam logic [1:0] ST_GP_RESP      = 2'b10;
    localparam logic [1:0] ST_GP_RESP_MISS = 2'b11;

    logic [1:0]        state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic              gp_rd, gp_rd_nxt;
    logic [DATA_W-1:0] vga_hold, gp_hold;
    logic              gp_inflight, gp_pend, gp_slot, vga_slot, at_limit;
    logic              vga_resp, gp_resp;

    // Both GP response states have the MSB set; that is the in-flight cycle.
    assign gp_inflight = state[1];
    assign gp_pend     = bus.gp_req & ~gp_inflight;
    assign at_limit    = (wait_cnt == CNT_W'(WAIT_MAX));
    assign vga_resp    = (state == ST_VGA_RESP);
    assign gp_resp     = state[1];

    // Slot decision, memory drive and next owner tag.
    always_comb begin
        gp_slot       = 1'b0;
        vga_slot      = 1'b0;
        state_nxt     = ST_IDLE;
        wait_cnt_nxt  = wait_cnt;
        gp_rd_nxt     = gp_rd;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        bus.mem_oe    = 1'b0;

        // No slot is granted while reset holds the tag register.
        if (rst_n) begin
            if (gp_pend && (!bus.vga_req || at_limit)) begin
                gp_slot = 1'b1;
            end else if (bus.vga_req) begin
                vga_slot = 1'b1;
            end
        end

        if (gp_slot) begin
            bus.mem_addr  = bus.gp_addr;
            bus.mem_wdata = bus.gp_wdata;
            bus.mem_we    = bus.gp_we;
            bus.mem_oe    = ~bus.gp_we;
            gp_rd_nxt     = ~bus.gp_we;
            state_nxt     = bus.vga_req ? ST_GP_RESP_MISS : ST_GP_RESP;
        end else if (vga_slot) begin
            bus.mem_addr = bus.vga_addr;
            bus.mem_oe   = 1'b1;
            state_nxt    = ST_VGA_RESP;
        end

        if (!bus.gp_req || gp_slot) begin
            wait_cnt_nxt = '0;
        end else if (gp_pend && !at_limit) begin
            wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            gp_rd    <= 1'b0;
            vga_hold <= '0;
            gp_hold  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            gp_rd    <= gp_rd_nxt;
            if (vga_resp) begin
                vga_hold <= bus.mem_rdata;
            end
            if (gp_resp && gp_rd) begin
                gp_hold <= bus.mem_rdata;
            end
        end
    end

    // RAM data is registered, so the response cycle forwards it directly.
    assign bus.vga_valid = vga_resp;
    assign bus.vga_miss  = (state == ST_GP_RESP_MISS);
    assign bus.gp_ack    = gp_resp;
    assign bus.vga_data  = vga_resp ? bus.mem_rdata : vga_hold;
    assign bus.gp_rdata  = (gp_resp && gp_rd) ? bus.mem_rdata : gp_hold;
endmodule
